// File: rtl/gray_counter_pkg.sv
// ---------------------------------------------------------------------------
// gray_counter_pkg
//   Shared helpers for Gray-coded counters and pointers.
//   gc_max_width       : widest value the helper functions handle
//   bin2gray(b)        : binary -> Gray, b ^ (b >> 1)
//   gray2bin(g)        : Gray -> binary, prefix XOR from the MSB down
//   Narrower callers zero-extend their operand and keep the low bits of the
//   result. Zero extension does not change either mapping.
// ---------------------------------------------------------------------------
package gray_counter_pkg;

    localparam int unsigned gc_max_width = 32;

    function automatic logic [gc_max_width-1:0] bin2gray(
        input logic [gc_max_width-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [gc_max_width-1:0] gray2bin(
        input logic [gc_max_width-1:0] g
    );
        logic [gc_max_width-1:0] b;
        b[gc_max_width-1] = g[gc_max_width-1];
        for (int i = gc_max_width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_bin2gray_conv.sv
// ---------------------------------------------------------------------------
// bin2gray_conv
//   Purely combinational binary-to-Gray converter of a configurable width.
//   Ports:
//     bin   in   width  binary value
//     gray  out  width  Gray code of bin
// ---------------------------------------------------------------------------
module bin2gray_conv #(
    parameter int unsigned width = 4
) (
    input  logic [width-1:0] bin,
    output logic [width-1:0] gray
);
    // A logical right shift brings a zero into the MSB. Because of that the
    // Gray MSB equals the binary MSB, with no special case needed.
    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
//   Up/down counter. It keeps a binary count and a registered Gray copy that
//   changes exactly one bit per step. The Gray copy is safe for CDC
//   synchronisers. The counter supports synchronous load, enable, direction,
//   and either wrap or saturate at the limits.
//   Parameters:
//     width     count width in bits (>= 2)
//     saturate  0: wrap modulo 2^width, 1: hold at the limit
//   Ports:
//     clk     in   1      rising-edge clock
//     rst     in   1      synchronous active-high reset (wins over everything)
//     en      in   1      step enable
//     dir     in   1      1 = up, 0 = down (only used when en=1, load=0)
//     load    in   1      load b_in (wins over en)
//     b_in    in   width  binary load value
//     b_out   out  width  registered binary count
//     g_out   out  width  registered Gray count = b_out ^ (b_out >> 1)
//     tc_out  out  1      one-cycle pulse on a wrap or a blocked step
// ---------------------------------------------------------------------------
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int unsigned width    = 4,
    parameter bit          saturate = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [width-1:0] b_in,
    output logic [width-1:0] b_out,
    output logic [width-1:0] g_out,
    output logic             tc_out
);

    localparam logic [width-1:0] count_one = {{(width-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] count_max = {width{1'b1}};

    logic [width-1:0] b_q;
    logic [width-1:0] g_q;
    logic             tc_q;

    logic [width-1:0] b_next;
    logic [width-1:0] g_next;
    logic             tc_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (b_q == count_max);
    assign at_zero = (b_q == '0);

    // Next-state mux: load, then step, then hold. Reset is applied in the
    // register block so that it overrides this whole mux.
    always_comb begin
        b_next  = b_q;
        tc_next = 1'b0;
        if (load) begin
            b_next = b_in;
        end else if (en) begin
            if (dir) begin
                if (at_max) begin
                    tc_next = 1'b1;
                    b_next  = saturate ? b_q : '0;
                end else begin
                    b_next = b_q + count_one;
                end
            end else begin
                if (at_zero) begin
                    tc_next = 1'b1;
                    b_next  = saturate ? b_q : count_max;
                end else begin
                    b_next = b_q - count_one;
                end
            end
        end
    end

    // The Gray value comes from the next-state binary value. Both registers
    // therefore load on the same edge and never disagree.
    bin2gray_conv #(
        .width (width)
    ) u_conv (
        .bin  (b_next),
        .gray (g_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q  <= '0;
            g_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            b_q  <= b_next;
            g_q  <= g_next;
            tc_q <= tc_next;
        end
    end

    assign b_out  = b_q;
    assign g_out  = g_q;
    assign tc_out = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_counter
//   Directed checks of a wrapping (dut_w) and a saturating (dut_s) 4-bit
//   gray_counter. The two counters share all their inputs.
// ---------------------------------------------------------------------------
module tb_gray_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] b_in;

    logic [3:0] b_w, g_w;
    logic       tc_w;
    logic [3:0] b_s, g_s;
    logic       tc_s;

    int checks = 0;
    int errors = 0;

    gray_counter #(.width(4), .saturate(1'b0)) dut_w (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .dir    (dir),
        .load   (load),
        .b_in   (b_in),
        .b_out  (b_w),
        .g_out  (g_w),
        .tc_out (tc_w)
    );

    gray_counter #(.width(4), .saturate(1'b1)) dut_s (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .dir    (dir),
        .load   (load),
        .b_in   (b_in),
        .b_out  (b_s),
        .g_out  (g_s),
        .tc_out (tc_s)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle, so outputs are read away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; b_in = 4'b1010; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({b_w, g_w, tc_w} !== {4'b0000, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_w[%0d]: got b=%b g=%b tc=%b want b=0000 g=0000 tc=0", i, b_w, g_w, tc_w);
            end
            checks++;
            if ({b_s, g_s, tc_s} !== {4'b0000, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_s[%0d]: got b=%b g=%b tc=%b want b=0000 g=0000 tc=0", i, b_s, g_s, tc_s);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_up_sweep();
        logic [3:0] exp_g [16];
        logic [3:0] exp_b;
        exp_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                  4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_b = 4'(i + 1);
            checks++;
            if ({b_w, g_w, tc_w} !== {exp_b, exp_g[i], (i == 15)}) begin
                errors++;
                $display("FAIL up_sweep[%0d]: got b=%b g=%b tc=%b want b=%b g=%b tc=%b",
                         i, b_w, g_w, tc_w, exp_b, exp_g[i], (i == 15));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [8:0] exp_v [2];
        exp_v = '{{4'b1111, 4'b1000, 1'b1}, {4'b1110, 4'b1001, 1'b0}};
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({b_w, g_w, tc_w} !== exp_v[i]) begin
                errors++;
                $display("FAIL down_wrap[%0d]: got b=%b g=%b tc=%b want {b,g,tc}=%b", i, b_w, g_w, tc_w, exp_v[i]);
            end
        end
        // Disabled cycle: the count holds and tc stays low.
        en = 1'b0;
        tick();
        checks++;
        if ({b_w, g_w, tc_w} !== {4'b1110, 4'b1001, 1'b0}) begin
            errors++;
            $display("FAIL hold: got b=%b g=%b tc=%b want b=1110 g=1001 tc=0", b_w, g_w, tc_w);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; b_in = 4'b1010; en = 1'b1; dir = 1'b1;
        tick();
        checks++;
        if ({b_w, g_w, tc_w} !== {4'b1010, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL load_priority: got b=%b g=%b tc=%b want b=1010 g=1111 tc=0", b_w, g_w, tc_w);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_saturate();
        logic [8:0] exp_s [3];
        logic [8:0] exp_w [3];
        exp_s = '{{4'b1111, 4'b1000, 1'b0}, {4'b1111, 4'b1000, 1'b1}, {4'b1111, 4'b1000, 1'b1}};
        exp_w = '{{4'b1111, 4'b1000, 1'b0}, {4'b0000, 4'b0000, 1'b1}, {4'b0001, 4'b0001, 1'b0}};
        load = 1'b1; b_in = 4'b1110;
        tick();
        load = 1'b0;
        checks++;
        if ({b_s, g_s, tc_s} !== {4'b1110, 4'b1001, 1'b0}) begin
            errors++;
            $display("FAIL sat_load: got b=%b g=%b tc=%b want b=1110 g=1001 tc=0", b_s, g_s, tc_s);
        end
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({b_s, g_s, tc_s} !== exp_s[i]) begin
                errors++;
                $display("FAIL sat_up[%0d]: got b=%b g=%b tc=%b want {b,g,tc}=%b", i, b_s, g_s, tc_s, exp_s[i]);
            end
            checks++;
            if ({b_w, g_w, tc_w} !== exp_w[i]) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got b=%b g=%b tc=%b want {b,g,tc}=%b", i, b_w, g_w, tc_w, exp_w[i]);
            end
        end
        dir = 1'b0;
        tick();
        checks++;
        if ({b_s, g_s, tc_s} !== {4'b1110, 4'b1001, 1'b0}) begin
            errors++;
            $display("FAIL sat_down: got b=%b g=%b tc=%b want b=1110 g=1001 tc=0", b_s, g_s, tc_s);
        end
        checks++;
        if ({b_w, g_w, tc_w} !== {4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL wrap_down: got b=%b g=%b tc=%b want b=0000 g=0000 tc=0", b_w, g_w, tc_w);
        end
        // Lower limit: the saturating counter is blocked at zero, the
        // wrapping counter wraps to all-ones.
        en = 1'b0; load = 1'b1; b_in = 4'b0000;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b0;
        tick();
        checks++;
        if ({b_s, g_s, tc_s} !== {4'b0000, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL sat_zero: got b=%b g=%b tc=%b want b=0000 g=0000 tc=1", b_s, g_s, tc_s);
        end
        checks++;
        if ({b_w, g_w, tc_w} !== {4'b1111, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_zero: got b=%b g=%b tc=%b want b=1111 g=1000 tc=1", b_w, g_w, tc_w);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        logic [8:0] exp_v [4];
        exp_v = '{{4'b0101, 4'b0111, 1'b0}, {4'b0000, 4'b0000, 1'b0},
                  {4'b0001, 4'b0001, 1'b0}, {4'b0010, 4'b0011, 1'b0}};
        load = 1'b1; b_in = 4'b0100;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rst = (i == 1);
            tick();
            checks++;
            if ({b_w, g_w, tc_w} !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got b=%b g=%b tc=%b want {b,g,tc}=%b", i, b_w, g_w, tc_w, exp_v[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Direction flips on consecutive enabled cycles, starting from 0010.
        logic       dirs  [4];
        logic [8:0] exp_v [4];
        dirs  = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp_v = '{{4'b0001, 4'b0001, 1'b0}, {4'b0010, 4'b0011, 1'b0},
                  {4'b0011, 4'b0010, 1'b0}, {4'b0010, 4'b0011, 1'b0}};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir = dirs[i];
            tick();
            checks++;
            if ({b_w, g_w, tc_w} !== exp_v[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got b=%b g=%b tc=%b want {b,g,tc}=%b", i, b_w, g_w, tc_w, exp_v[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; b_in = 4'b0000;
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_load_priority();
        test_saturate();
        test_reset_mid_count();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
